// File: rtl/approx_arith_pipe.sv
// Two-stage valid/ready approximate add/multiply unit with per-beat LSB truncation level,
// fixed-point multiply, and saturating or wrapping result range handling.
module approx_arith_pipe #(
   parameter int WIDTH        = 32,
   parameter int MUL_IN_WIDTH = 16,
   parameter int FRAC_BITS    = 8,
   parameter int TRUNC_STEP   = 4,
   parameter int NUM_LEVELS   = 4,
   parameter int SATURATE     = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_op,
   input  logic [$clog2(NUM_LEVELS)-1:0] in_level,
   input  logic [WIDTH-1:0]              in_a,
   input  logic [WIDTH-1:0]              in_b,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic                          out_ovf,
   output logic [15:0]                   ovf_count
);

   localparam int LVL_W = $clog2(NUM_LEVELS);
   localparam int MW    = MUL_IN_WIDTH;
   // Wide enough for both the add carry and the full product, plus one guard bit
   localparam int RW    = ((WIDTH + 1) > (2 * MW)) ? (WIDTH + 2) : (2 * MW + 1);

   logic                    en_s;
   logic                    accept_s;
   logic [LVL_W-1:0]        lvl_s;
   logic [15:0]             t_s;
   logic [WIDTH-1:0]        add_mask_s;
   logic [MW-1:0]           mul_mask_s;
   logic [WIDTH-1:0]        a_trunc_s;
   logic [WIDTH-1:0]        b_trunc_s;

   logic                    v1_r;
   logic                    op1_r;
   logic [WIDTH-1:0]        a1_r;
   logic [WIDTH-1:0]        b1_r;

   logic [WIDTH:0]          sum_s;
   logic signed [2*MW-1:0]  ma_s;
   logic signed [2*MW-1:0]  mb_s;
   logic signed [2*MW-1:0]  prod_s;
   logic signed [2*MW-1:0]  prod_sh_s;
   logic [RW-1:0]           full_s;
   logic                    ovf_s;
   logic [WIDTH-1:0]        res_s;

   assign en_s     = ~out_valid | out_ready;
   assign in_ready = en_s;
   assign accept_s = in_valid & en_s;

   // Clamp the requested level and zero the truncated operand LSBs
   always_comb begin
      if (int'(in_level) >= NUM_LEVELS) begin
         lvl_s = LVL_W'(NUM_LEVELS - 1);
      end else begin
         lvl_s = in_level;
      end
      t_s = 16'(lvl_s) * 16'(TRUNC_STEP);
      for (int i = 0; i < WIDTH; i++) begin
         add_mask_s[i] = (i >= int'(t_s));
      end
      for (int i = 0; i < MW; i++) begin
         mul_mask_s[i] = (i >= int'(t_s));
      end
      if (in_op) begin
         a_trunc_s = WIDTH'(in_a[MW-1:0] & mul_mask_s);
         b_trunc_s = WIDTH'(in_b[MW-1:0] & mul_mask_s);
      end else begin
         a_trunc_s = in_a & add_mask_s;
         b_trunc_s = in_b & add_mask_s;
      end
   end

   // Stage 1: capture op and truncated operands of an accepted beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_r  <= 1'b0;
         op1_r <= 1'b0;
         a1_r  <= {WIDTH{1'b0}};
         b1_r  <= {WIDTH{1'b0}};
      end else if (en_s) begin
         v1_r <= accept_s;
         if (accept_s) begin
            op1_r <= in_op;
            a1_r  <= a_trunc_s;
            b1_r  <= b_trunc_s;
         end
      end
   end

   // Compute the exact result, detect range overflow, pick clamped or wrapped value
   always_comb begin
      sum_s     = {a1_r[WIDTH-1], a1_r} + {b1_r[WIDTH-1], b1_r};
      ma_s      = {{MW{a1_r[MW-1]}}, a1_r[MW-1:0]};
      mb_s      = {{MW{b1_r[MW-1]}}, b1_r[MW-1:0]};
      prod_s    = ma_s * mb_s;
      prod_sh_s = prod_s >>> FRAC_BITS;
      if (op1_r) begin
         full_s = {{(RW - 2*MW){prod_sh_s[2*MW-1]}}, prod_sh_s};
      end else begin
         full_s = {{(RW - WIDTH - 1){sum_s[WIDTH]}}, sum_s};
      end
      // In range exactly when every bit from the result sign upward agrees
      ovf_s = ~((&full_s[RW-1:WIDTH-1]) | ~(|full_s[RW-1:WIDTH-1]));
      if (ovf_s && (SATURATE != 0)) begin
         if (full_s[RW-1]) begin
            res_s = {1'b1, {(WIDTH-1){1'b0}}};
         end else begin
            res_s = {1'b0, {(WIDTH-1){1'b1}}};
         end
      end else begin
         res_s = full_s[WIDTH-1:0];
      end
   end

   // Stage 2: output register, held while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= {WIDTH{1'b0}};
         out_ovf   <= 1'b0;
      end else if (en_s) begin
         out_valid <= v1_r;
         if (v1_r) begin
            out_data <= res_s;
            out_ovf  <= ovf_s;
         end
      end
   end

   // Count delivered overflowed results, sticking at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_count <= 16'h0000;
      end else if (out_valid && out_ready && out_ovf && (ovf_count != 16'hFFFF)) begin
         ovf_count <= ovf_count + 16'h0001;
      end
   end

endmodule

// File: tb/tb_approx_arith_pipe.sv
// Bench for approx_arith_pipe: directed vector table, randomized scoreboard run,
// backpressure and mid-operation reset sequences; a wrapping build runs alongside.
module tb_approx_arith_pipe;

   localparam int NUM_LVL = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_op = 1'b0;
   logic [1:0]  in_level = 2'd0;
   logic [31:0] in_a = 32'h0;
   logic [31:0] in_b = 32'h0;
   logic        out_ready = 1'b1;
   logic        in_ready, out_valid, out_ovf;
   logic [31:0] out_data;
   logic [15:0] ovf_count;
   logic        in_ready_w, out_valid_w, out_ovf_w;
   logic [31:0] out_data_w;
   logic [15:0] ovf_count_w;

   always #5 clk = ~clk;

   approx_arith_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_level(in_level), .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ovf(out_ovf), .ovf_count(ovf_count)
   );

   approx_arith_pipe #(.SATURATE(0)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w), .in_op(in_op),
      .in_level(in_level), .in_a(in_a), .in_b(in_b), .out_valid(out_valid_w), .out_ready(out_ready),
      .out_data(out_data_w), .out_ovf(out_ovf_w), .ovf_count(ovf_count_w)
   );

   typedef struct {
      logic        op;
      logic [1:0]  lvl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] d;
      logic [31:0] dw;
      logic        o;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic [31:0] dw;
      logic        o;
   } exp_t;

   vec_t  vecs[10];
   exp_t  sb_q[$];
   int    checks = 0;
   int    errors = 0;
   bit    sb_en = 1'b0;
   int    mcnt = 0;
   int    deliv_cnt = 0;
   int    tbl_cnt = 0;
   bit    prev_stall = 1'b0;
   logic [31:0] prev_data = 32'h0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Reference: plain integer arithmetic on the truncated operands
   function automatic void model(input logic op, input logic [1:0] lvl, input logic [31:0] a,
                                 input logic [31:0] b, input bit sat,
                                 output logic [31:0] d, output logic ovf);
      int     lv, t;
      longint mask, r, hi, lo;
      logic [31:0] am, bm;
      logic [15:0] ma, mb;
      lv   = (int'(lvl) >= NUM_LVL) ? NUM_LVL - 1 : int'(lvl);
      t    = lv * 4;
      mask = (longint'(1) << t) - 1;
      if (!op) begin
         am = a & ~32'(mask);
         bm = b & ~32'(mask);
         r  = longint'($signed(am)) + longint'($signed(bm));
      end else begin
         if (t >= 16) begin
            ma = 16'h0;
            mb = 16'h0;
         end else begin
            ma = a[15:0] & ~16'(mask);
            mb = b[15:0] & ~16'(mask);
         end
         r = (longint'($signed(ma)) * longint'($signed(mb))) >>> 8;
      end
      hi  = longint'(32'h7FFF_FFFF);
      lo  = -hi - 1;
      ovf = (r > hi) || (r < lo);
      if (ovf && sat) d = (r > hi) ? 32'h7FFF_FFFF : 32'h8000_0000;
      else            d = r[31:0];
   endfunction

   // Scoreboard monitor, sampling mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (sb_en) begin
         chk("ovf_count", {48'h0, ovf_count}, 64'(mcnt));
         chk("ovf_count_wrapbuild", {48'h0, ovf_count_w}, 64'(mcnt));
         chk("in_ready_rule", {63'h0, in_ready}, {63'h0, (!out_valid || out_ready)});
         chk("in_ready_wrapbuild", {63'h0, in_ready_w}, {63'h0, in_ready});
         chk("out_valid_wrapbuild", {63'h0, out_valid_w}, {63'h0, out_valid});
         if (prev_stall) begin
            chk("stall_valid", {63'h0, out_valid}, 64'h1);
            chk("stall_data", {32'h0, out_data}, {32'h0, prev_data});
         end
         if (in_valid && in_ready) begin
            model(in_op, in_level, in_a, in_b, 1'b1, e.d, e.o);
            model(in_op, in_level, in_a, in_b, 1'b0, e.dw, e.o);
            sb_q.push_back(e);
         end
         if (out_valid && out_ready) begin
            deliv_cnt++;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result actual=%0h required=none", out_data);
            end else begin
               e = sb_q.pop_front();
               chk("sb_data", {32'h0, out_data}, {32'h0, e.d});
               chk("sb_ovf", {63'h0, out_ovf}, {63'h0, e.o});
               chk("sb_data_wrapbuild", {32'h0, out_data_w}, {32'h0, e.dw});
               chk("sb_ovf_wrapbuild", {63'h0, out_ovf_w}, {63'h0, e.o});
               if (e.o && mcnt < 65535) mcnt++;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic run_vec(input int i);
      int lat;
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_op     = vecs[i].op;
      in_level  = vecs[i].lvl;
      in_a      = vecs[i].a;
      in_b      = vecs[i].b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_data", i), {32'h0, out_data}, {32'h0, vecs[i].d});
      chk($sformatf("vec%0d_ovf", i), {63'h0, out_ovf}, {63'h0, vecs[i].o});
      chk($sformatf("vec%0d_data_wrap", i), {32'h0, out_data_w}, {32'h0, vecs[i].dw});
      if (vecs[i].o) tbl_cnt++;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ovf_count", i), {48'h0, ovf_count}, 64'(tbl_cnt));
   endtask

   initial begin
      int k, cyc, d0;
      bit saw_block, acc;
      vecs[0] = '{1'b0, 2'd0, 32'h0000_1234, 32'h0000_0FFF, 32'h0000_2233, 32'h0000_2233, 1'b0};
      vecs[1] = '{1'b0, 2'd2, 32'h0000_01FF, 32'h0000_01FF, 32'h0000_0200, 32'h0000_0200, 1'b0};
      vecs[2] = '{1'b1, 2'd0, 32'h0000_0300, 32'h0000_FE00, 32'hFFFF_FA00, 32'hFFFF_FA00, 1'b0};
      vecs[3] = '{1'b0, 2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1};
      vecs[4] = '{1'b0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
      vecs[5] = '{1'b0, 2'd3, 32'h0000_0FFF, 32'h0000_1001, 32'h0000_1000, 32'h0000_1000, 1'b0};
      vecs[6] = '{1'b1, 2'd3, 32'h0000_1234, 32'h0000_2345, 32'h0002_0000, 32'h0002_0000, 1'b0};
      vecs[7] = '{1'b1, 2'd0, 32'hABCD_0100, 32'h1234_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 1'b0};
      vecs[8] = '{1'b1, 2'd1, 32'h0000_801F, 32'h0000_8000, 32'h003F_F800, 32'h003F_F800, 1'b0};
      vecs[9] = '{1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
      chk("rst_out_data", {32'h0, out_data}, 64'h0);
      chk("rst_out_ovf", {63'h0, out_ovf}, 64'h0);
      chk("rst_ovf_count", {48'h0, ovf_count}, 64'h0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
      sb_en = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(i);

      // Randomized traffic with random backpressure
      for (int n = 0; n < 400; n++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         in_op     = 1'($urandom_range(0, 1));
         in_level  = 2'($urandom_range(0, 3));
         in_a      = $urandom;
         in_b      = $urandom;
         if ($urandom_range(0, 3) == 0) in_a = 32'h7FFF_F000 ^ 32'($urandom_range(0, 4095));
         if ($urandom_range(0, 3) == 0) in_b = 32'h8000_0FFF ^ 32'($urandom_range(0, 4095));
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("random_drain", 64'(sb_q.size()), 64'd0);

      // Four back-to-back adds with the consumer stalled for five cycles
      d0 = deliv_cnt;
      k = 0;
      saw_block = 1'b0;
      for (cyc = 0; cyc < 40; cyc++) begin
         in_valid  = (k < 4);
         in_op     = 1'b0;
         in_level  = 2'd0;
         in_a      = 32'h0000_1000 * 32'(k + 1);
         in_b      = 32'h0000_0011;
         out_ready = (cyc >= 5);
         @(negedge clk);
         acc = in_valid && in_ready;
         if (in_valid && !in_ready) saw_block = 1'b1;
         @(posedge clk); #1;
         if (acc) k++;
      end
      in_valid = 1'b0;
      chk("bp_all_accepted", 64'(k), 64'd4);
      chk("bp_in_ready_dropped", {63'h0, saw_block}, 64'h1);
      chk("bp_delivered", 64'(deliv_cnt - d0), 64'd4);
      chk("bp_no_leftover", 64'(sb_q.size()), 64'd0);

      // Reset while both stages hold beats
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_op     = 1'b0;
      in_level  = 2'd0;
      in_a      = 32'h7FFF_FFFF;
      in_b      = 32'h0000_0005;
      @(posedge clk); #1;
      in_a = 32'h0000_0042;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("pre_rst_out_valid", {63'h0, out_valid}, 64'h1);
      sb_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {63'h0, out_valid}, 64'h0);
      chk("midrst_out_data", {32'h0, out_data}, 64'h0);
      chk("midrst_out_ovf", {63'h0, out_ovf}, 64'h0);
      chk("midrst_ovf_count", {48'h0, ovf_count}, 64'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb_q.delete();
      mcnt    = 0;
      tbl_cnt = 0;
      sb_en   = 1'b1;
      run_vec(0);
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_no_ghost", 64'(sb_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
